// File: rtl/video_stream_pkg.sv
// Shared definitions for the video stream broadcast block: beat layout and
// pointer-width helper.
package video_stream_pkg;

    localparam int unsigned VID_DATA_W_DEF = 24;
    localparam int unsigned VID_BEAT_W     = VID_DATA_W_DEF + 2;

    // Beat layout: {tuser, tlast, tdata}
    localparam int unsigned VID_DATA_OFS   = 0;

    function automatic int unsigned vid_beat_w(input int unsigned data_w);
        return data_w + 2;
    endfunction

    function automatic int unsigned vid_last_ofs(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned vid_user_ofs(input int unsigned data_w);
        return data_w + 1;
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/video_stream_fifo.sv
// First-word-fall-through FIFO for one broadcast output; storage is not reset,
// only the pointers and occupancy count.
module video_stream_fifo
    import video_stream_pkg::*;
#(
    parameter int unsigned W     = 26,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/video_stream_broadcast.sv
// AXI4-Stream video fork: replicates one input stream to NUM_OUT outputs, each
// buffered by its own FIFO, with the output enable mask latched on SOF beats.
module video_stream_broadcast
    import video_stream_pkg::*;
#(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned NUM_OUT    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_OUT-1:0]        en_mask,
    input  logic [DATA_W-1:0]         s_axis_video_tdata,
    input  logic                      s_axis_video_tvalid,
    output logic                      s_axis_video_tready,
    input  logic                      s_axis_video_tlast,
    input  logic                      s_axis_video_tuser,
    output logic [NUM_OUT*DATA_W-1:0] m_axis_video_tdata,
    output logic [NUM_OUT-1:0]        m_axis_video_tvalid,
    input  logic [NUM_OUT-1:0]        m_axis_video_tready,
    output logic [NUM_OUT-1:0]        m_axis_video_tlast,
    output logic [NUM_OUT-1:0]        m_axis_video_tuser,
    output logic [NUM_OUT-1:0]        active_mask,
    output logic [15:0]               frame_cnt
);

    localparam int unsigned BEAT_W   = vid_beat_w(DATA_W);
    localparam int unsigned LAST_OFS = vid_last_ofs(DATA_W);
    localparam int unsigned USER_OFS = vid_user_ofs(DATA_W);

    if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num_out
        $error("NUM_OUT must be in 1..8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    logic [NUM_OUT-1:0] active_mask_q, active_mask_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [NUM_OUT-1:0] rmask;
    logic [NUM_OUT-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [BEAT_W-1:0]  beat_in;
    logic               sof, accept;

    // SOF beats route by the newly requested mask; all others by the latched one.
    assign sof     = s_axis_video_tuser;
    assign rmask   = sof ? en_mask : active_mask_q;
    assign beat_in = {s_axis_video_tuser, s_axis_video_tlast, s_axis_video_tdata};

    assign s_axis_video_tready = &(~rmask | ~fifo_full);
    assign accept              = s_axis_video_tvalid && s_axis_video_tready;
    assign fifo_push           = {NUM_OUT{accept}} & rmask;
    assign fifo_pop            = ~fifo_empty & m_axis_video_tready;

    always_comb begin
        active_mask_d = active_mask_q;
        frame_cnt_d   = frame_cnt_q;
        if (accept && sof) begin
            active_mask_d = en_mask;
            frame_cnt_d   = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_mask_q <= '0;
            frame_cnt_q   <= '0;
        end else begin
            active_mask_q <= active_mask_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign active_mask = active_mask_q;
    assign frame_cnt   = frame_cnt_q;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        logic [BEAT_W-1:0] beat_out;

        video_stream_fifo #(
            .W     (BEAT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[g]),
            .din   (beat_in),
            .full  (fifo_full[g]),
            .pop   (fifo_pop[g]),
            .dout  (beat_out),
            .empty (fifo_empty[g])
        );

        assign m_axis_video_tdata[g*DATA_W +: DATA_W] = beat_out[VID_DATA_OFS +: DATA_W];
        assign m_axis_video_tlast[g]  = beat_out[LAST_OFS];
        assign m_axis_video_tuser[g]  = beat_out[USER_OFS];
        assign m_axis_video_tvalid[g] = !fifo_empty[g];
    end

endmodule

// File: tb/tb_video_stream_broadcast.sv
// Scoreboard bench for video_stream_broadcast: a queue-based reference model
// predicts every output beat, ready, mask and frame count.
module tb_video_stream_broadcast;

    localparam int DW    = 24;
    localparam int NO    = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic          user;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NO-1:0]     en_mask;
    logic [DW-1:0]     s_tdata;
    logic              s_tvalid, s_tready, s_tlast, s_tuser;
    logic [NO*DW-1:0]  m_tdata;
    logic [NO-1:0]     m_tvalid, m_tready, m_tlast, m_tuser;
    logic [NO-1:0]     active_mask;
    logic [15:0]       frame_cnt;

    always #5 clk = ~clk;

    video_stream_broadcast #(
        .DATA_W     (DW),
        .NUM_OUT    (NO),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .en_mask             (en_mask),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tready (s_tready),
        .s_axis_video_tlast  (s_tlast),
        .s_axis_video_tuser  (s_tuser),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tvalid (m_tvalid),
        .m_axis_video_tready (m_tready),
        .m_axis_video_tlast  (m_tlast),
        .m_axis_video_tuser  (m_tuser),
        .active_mask         (active_mask),
        .frame_cnt           (frame_cnt)
    );

    // Reference model state
    beat_t         exp_q [NO][$];
    logic [NO-1:0] mask_m;
    logic [15:0]   cnt_m;
    bit            acc_m;
    logic [NO-1:0] rm_m;
    bit            mon_en = 1'b0;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_ready();
        logic [NO-1:0] rm;
        rm = s_tuser ? en_mask : mask_m;
        for (int i = 0; i < NO; i++) begin
            if (rm[i] && exp_q[i].size() >= DEPTH) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NO; i++) exp_q[i].delete();
            mask_m = '0;
            cnt_m  = '0;
            acc_m  = 1'b0;
        end else begin
            rm_m  = s_tuser ? en_mask : mask_m;
            acc_m = s_tvalid && model_ready();
            for (int i = 0; i < NO; i++) begin
                if (exp_q[i].size() > 0 && m_tready[i]) void'(exp_q[i].pop_front());
            end
            if (acc_m) begin
                for (int i = 0; i < NO; i++) begin
                    if (rm_m[i]) exp_q[i].push_back('{s_tuser, s_tlast, s_tdata});
                end
                if (s_tuser) begin
                    mask_m = en_mask;
                    cnt_m  = cnt_m + 16'd1;
                end
            end
        end
    end

    // Monitor: compare DUT against the scoreboard away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            check("s_tready", 32'(s_tready), 32'(model_ready()));
            check("active_mask", 32'(active_mask), 32'(mask_m));
            check("frame_cnt", 32'(frame_cnt), 32'(cnt_m));
            for (int i = 0; i < NO; i++) begin
                check($sformatf("m_tvalid[%0d]", i), 32'(m_tvalid[i]), 32'(exp_q[i].size() > 0));
                if (exp_q[i].size() > 0 && m_tvalid[i]) begin
                    check($sformatf("m_tdata[%0d]", i), 32'(m_tdata[i*DW +: DW]), 32'(exp_q[i][0].data));
                    check($sformatf("m_tlast[%0d]", i), 32'(m_tlast[i]), 32'(exp_q[i][0].last));
                    check($sformatf("m_tuser[%0d]", i), 32'(m_tuser[i]), 32'(exp_q[i][0].user));
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) cycle();
    endtask

    // Holds a beat until it is accepted, bounded by a cycle budget
    task automatic send(input bit u, input bit l, input logic [DW-1:0] d);
        int waited;
        s_tvalid = 1'b1;
        s_tuser  = u;
        s_tlast  = l;
        s_tdata  = d;
        waited   = 0;
        do begin
            cycle();
            waited++;
        end while (!acc_m && waited < 200);
        if (!acc_m) check("send_timeout", 32'(waited), 32'(0));
        s_tvalid = 1'b0;
    endtask

    // Offers n back-to-back beats, counting cycles in which the DUT was ready
    task automatic stream(input int n, input bit first_sof, output int ready_cnt);
        ready_cnt = 0;
        for (int k = 0; k < n; k++) begin
            s_tvalid = 1'b1;
            s_tuser  = first_sof && (k == 0);
            s_tlast  = (k % 10) == 9;
            s_tdata  = DW'($urandom);
            @(negedge clk);
            if (s_tready) ready_cnt++;
            cycle();
        end
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
    endtask

    int rc;

    initial begin
        rst      = 1'b1;
        en_mask  = '0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        m_tready = '1;
        repeat (2) cycle();
        rst    = 1'b0;
        mon_en = 1'b1;

        @(negedge clk);
        check("reset_tvalid", 32'(m_tvalid), 32'(0));
        check("reset_active_mask", 32'(active_mask), 32'(0));
        check("reset_frame_cnt", 32'(frame_cnt), 32'(0));
        check("reset_tready", 32'(s_tready), 32'(1));
        cycle();

        // Non-SOF beats after reset are sunk, then a first SOF line
        en_mask = 2'b11;
        send(1'b0, 1'b0, 24'h0000AA);
        send(1'b0, 1'b0, 24'h0000BB);
        @(negedge clk);
        check("presof_tvalid", 32'(m_tvalid), 32'(0));
        cycle();
        for (int k = 1; k <= 4; k++) send(k == 1, k == 4, DW'(k));
        idle(4);
        check("first_frame_cnt", 32'(frame_cnt), 32'(1));
        check("first_active_mask", 32'(active_mask), 32'(2'b11));

        // Output 1 stalled: its FIFO fills and backpressures the input
        m_tready = 2'b01;
        fork
            for (int k = 0; k < 8; k++) send(k == 0, k == 7, 24'h100 + DW'(k));
            begin
                repeat (8) cycle();
                @(negedge clk);
                check("stall_tready", 32'(s_tready), 32'(0));
                cycle();
                m_tready = 2'b11;
            end
        join
        idle(6);

        // Mask change mid-frame takes effect only at the next SOF
        send(1'b1, 1'b0, 24'h200);
        send(1'b0, 1'b0, 24'h201);
        en_mask = 2'b01;
        for (int k = 2; k < 6; k++) send(1'b0, k == 5, 24'h200 + DW'(k));
        idle(4);
        m_tready = 2'b01;
        stream(12, 1'b1, rc);
        check("disabled_bp_ignored", 32'(rc), 32'(12));
        check("mask_01", 32'(active_mask), 32'(2'b01));

        // Full throughput on a 100-beat frame
        m_tready = 2'b11;
        en_mask  = 2'b11;
        idle(10);
        stream(100, 1'b1, rc);
        check("throughput_100", 32'(rc), 32'(100));
        idle(6);

        // Reset mid-frame with beats buffered
        m_tready = 2'b00;
        send(1'b1, 1'b0, 24'h300);
        send(1'b0, 1'b0, 24'h301);
        send(1'b0, 1'b0, 24'h302);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_tvalid", 32'(m_tvalid), 32'(0));
        check("midrst_active_mask", 32'(active_mask), 32'(0));
        check("midrst_frame_cnt", 32'(frame_cnt), 32'(0));
        cycle();
        m_tready = 2'b11;
        for (int k = 0; k < 3; k++) send(1'b0, 1'b0, 24'h400 + DW'(k));
        @(negedge clk);
        check("postrst_sunk", 32'(m_tvalid), 32'(0));
        cycle();

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            s_tvalid = 1'($urandom_range(0, 3) != 0);
            s_tuser  = 1'($urandom_range(0, 15) == 0);
            s_tlast  = 1'($urandom_range(0, 7) == 0);
            s_tdata  = DW'($urandom);
            m_tready = NO'($urandom);
            if ($urandom_range(0, 9) == 0) en_mask = NO'($urandom);
            cycle();
        end
        s_tvalid = 1'b0;
        m_tready = '1;
        idle(DEPTH + 4);
        for (int i = 0; i < NO; i++) check($sformatf("drained[%0d]", i), 32'(exp_q[i].size()), 32'(0));

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/video_stream_broadcast.md
Name: video_stream_broadcast

Overview:
- Parametrised AXI4-Stream video fork: one slave video stream is replicated to NUM_OUT master streams.
- Correct fork handshake: an input beat is consumed only when every active output can store it.
- Each output has its own small FWFT FIFO, so one stalled consumer does not drop data on the others.
- Per-output enable mask is switched only on frame boundaries (tuser). Sits between the camera/VDMA input path and the downstream video consumers (display, encoder, processing).

Parameters:
- DATA_W, 24, pixel data width in bits.
- NUM_OUT, 2, number of master outputs (1..8).
- FIFO_DEPTH, 4, entries per output FIFO; power of two, minimum 2.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- en_mask  in  NUM_OUT  requested output enables; bit i = output i. Sampled only on SOF beats.
- s_axis_video_tdata  in  DATA_W  input pixel.
- s_axis_video_tvalid  in  1  input valid.
- s_axis_video_tready  out  1  input ready.
- s_axis_video_tlast  in  1  end of line.
- s_axis_video_tuser  in  1  start of frame (SOF).
- m_axis_video_tdata  out  NUM_OUT*DATA_W  output pixels; slice i = [i*DATA_W +: DATA_W].
- m_axis_video_tvalid  out  NUM_OUT  per-output valid.
- m_axis_video_tready  in  NUM_OUT  per-output ready.
- m_axis_video_tlast  out  NUM_OUT  per-output EOL.
- m_axis_video_tuser  out  NUM_OUT  per-output SOF.
- active_mask  out  NUM_OUT  mask currently applied to the frame in flight.
- frame_cnt  out  16  SOF beats accepted since reset; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - active_mask=0 and frame_cnt=0.
  - All FIFOs empty, so m_axis_video_tvalid=0.
  - s_axis_video_tready=1 after reset.
  - Reset asserted mid-frame discards all buffered beats immediately.
- Input beat classes:
  - sof = s_axis_video_tuser.
  - Routing mask: rmask = sof ? en_mask : active_mask.
- Input ready:
  - s_axis_video_tready = AND over i of (!rmask[i] || !full[i]).
  - rmask=0 means ready=1 and beats are sunk (discarded).
  - full[i] means count==FIFO_DEPTH. A pop in the same cycle does not free space, so there is no combinational tready path from m_tready to s_tready.
- Accept: s_axis_video_tvalid && s_axis_video_tready.
  - {tuser,tlast,tdata} is written to FIFO i for every i with rmask[i]=1.
  - If sof, active_mask <= en_mask and frame_cnt <= frame_cnt+1.
- Frame alignment:
  - After reset, and for any output disabled on the current frame, beats are dropped until the next SOF. An output never starts mid-frame.
  - en_mask changes between SOFs have no effect until the next accepted SOF.
  - en_mask is sampled at the accepted SOF beat, not when tvalid rises.
- FIFO (per output), first-word-fall-through:
  - Latency: a beat accepted at edge N has m_tvalid[i]=1 after edge N (1-cycle latency), with data stable until the pop.
  - Pop: m_tvalid[i] && m_tready[i].
  - Simultaneous push+pop: count unchanged, pointers both advance.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - m_axis_video_tvalid/tdata/tlast/tuser remain stable while tvalid=1 && tready=0.
- Throughput:
  - 1 beat/cycle when all active outputs have tready=1. With FIFO_DEPTH>=2, steady-state full throughput is kept because the consumer pops every cycle.
- Disabled outputs:
  - The FIFO drains the remaining beats of the previous frame normally, then holds tvalid=0.
- Degenerate SOF (en_mask=0 on SOF beat):
  - Frame is sunk, frame_cnt still increments, active_mask=0.

Decomposition:
- Package video_stream_pkg:
  - localparam VID_BEAT_W = DATA_W+2.
  - Beat field offsets (USER, LAST, DATA).
  - Function clog2 for pointer width.
- Sub-module video_stream_fifo (params W, DEPTH):
  - Ports clk, rst, push, din, full, pop, dout, empty.
  - Instantiated NUM_OUT times via generate.
- Top holds mask/rmask logic, ready AND-reduction and frame_cnt.

Test Plan:
- Reset, then feed 2 beats without SOF with en_mask=2'b11 -> s_tready=1, both beats discarded, m_tvalid=00. Then SOF line of 4 beats 0x000001..0x000004 (tlast on 4th) -> both outputs emit 0x000001..0x000004 with tuser on 1st and tlast on 4th, active_mask=11, frame_cnt=1.
- NUM_OUT=2, FIFO_DEPTH=4, m_tready=2'b01, stream 8 beats -> output 1 fills after 4 accepts, then s_tready=0. Raise m_tready[1] -> all 8 beats appear in order on both outputs, none lost or duplicated.
- Change en_mask 11->01 mid-frame -> output 1 keeps receiving the rest of that frame. At the next SOF active_mask=01, output 1 receives nothing, and s_tready ignores full[1].
- en_mask=01 while output 1 has m_tready=0 and a full FIFO -> input keeps flowing at 1 beat/cycle to output 0 (disabled-output backpressure ignored).
- All tready=1, 100-beat frame -> 100 accepts in 100 consecutive cycles. First m_tvalid appears 1 cycle after the first accept.
- Assert rst for 1 cycle with 3 beats buffered mid-frame -> next cycle m_tvalid=0, active_mask=0, frame_cnt=0. Subsequent non-SOF beats are sunk.
